ni_packetizer: RTL and testbench

- Network-interface transmitter that sits at a node's local port.
- Converts packet requests (destination X/Y, length) plus a payload word stream into a head/body/tail flit sequence for the router's local input port.
- The destination fields it stamps into each flit are what the router's routing computation consumes.
- Flow control is credit-based per virtual channel (VC). One packet is in flight at a time, held on one VC from head to tail.

---
 rtl/ni_packetizer.sv | 187 ++++++++++++++++++
 tb/tb_ni_packetizer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packetizer.sv
// ni_packetizer: network-interface transmitter for a node's local port.
// Turns a packet request (dest X/Y, length-1) plus a payload word stream into
// HEAD/BODY/TAIL (or HEADTAIL) flits toward the router local input port.
// One packet in flight at a time, pinned to one VC from head to tail; VCs are
// handed out round-robin and only once the downstream VC is fully drained.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pkt_valid_i / pkt_ready_o         packet request handshake
//   pkt_x_dest_i, pkt_y_dest_i        destination coordinates
//   pkt_len_i                         packet length minus 1 (flits)
//   payload_valid_i / payload_ready_o payload word handshake
//   payload_i                         payload word
//   flit_valid_o                      registered flit strobe (one cycle/flit)
//   flit_type_o                       00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL
//   flit_vc_o, flit_x_dest_o,
//   flit_y_dest_o, flit_payload_o     flit fields (hold between flits)
//   credit_valid_i, credit_vc_i       one returned credit and its VC
//   credit_err_o                      sticky: credit returned to a full counter

// Per-VC credit counter. A simultaneous send and return cancel out, which also
// keeps a full counter from flagging overflow in that cycle.
module ni_credit_ctr #(
  parameter int BUFFER_SIZE = 8,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  assign ovf = inc & ~dec & (cnt == CW'(BUFFER_SIZE));

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= CW'(BUFFER_SIZE);
    else if (inc && !dec && !ovf) cnt <= cnt + 1'b1;
    else if (dec && !inc)         cnt <= cnt - 1'b1;
  end
endmodule

module ni_packetizer #(
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4,
  parameter int VC_NUM           = 2,
  parameter int BUFFER_SIZE      = 8,
  parameter int PAYLOAD_SIZE     = 32,
  parameter int MAX_PKT_LEN      = 16,
  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int LW  = $clog2(MAX_PKT_LEN),
  localparam int CW  = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_valid_i,
  output logic                        pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i,
  input  logic [LW-1:0]               pkt_len_i,
  input  logic                        payload_valid_i,
  output logic                        payload_ready_o,
  input  logic [PAYLOAD_SIZE-1:0]     payload_i,
  output logic                        flit_valid_o,
  output logic [1:0]                  flit_type_o,
  output logic [VCW-1:0]              flit_vc_o,
  output logic [DEST_ADDR_SIZE_X-1:0] flit_x_dest_o,
  output logic [DEST_ADDR_SIZE_Y-1:0] flit_y_dest_o,
  output logic [PAYLOAD_SIZE-1:0]     flit_payload_o,
  input  logic                        credit_valid_i,
  input  logic [VCW-1:0]              credit_vc_i,
  output logic                        credit_err_o
);
  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  typedef enum logic [1:0] {IDLE, SELECT, SEND} state_t;
  state_t state, state_nxt;

  logic [DEST_ADDR_SIZE_X-1:0] x_q;
  logic [DEST_ADDR_SIZE_Y-1:0] y_q;
  logic [LW-1:0]               len_q, flit_cnt;
  logic [VCW-1:0]              cur_vc, rr_ptr, sel_vc, rr_nxt;
  logic                        sel_found, fire, last;
  logic [1:0]                  ftype;

  logic [VC_NUM-1:0][CW-1:0]   credit;
  logic [VC_NUM-1:0]           vc_full, inc, dec, ovf;

  assign fire = payload_valid_i & payload_ready_o;
  assign last = (flit_cnt == len_q);

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    assign inc[g]     = credit_valid_i && (credit_vc_i == VCW'(g));
    assign dec[g]     = fire && (cur_vc == VCW'(g));
    // Eligible only when the downstream VC has drained completely.
    assign vc_full[g] = (credit[g] == CW'(BUFFER_SIZE));
    ni_credit_ctr #(.BUFFER_SIZE(BUFFER_SIZE), .CW(CW)) u_ctr (
      .clk(clk), .rst(rst), .inc(inc[g]), .dec(dec[g]),
      .cnt(credit[g]), .ovf(ovf[g])
    );
  end

  // First eligible VC at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_vc    = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(rr_ptr) + i) % VC_NUM;
      if (!sel_found && vc_full[idx]) begin
        sel_found = 1'b1;
        sel_vc    = VCW'(idx);
      end
    end
    rr_nxt = VCW'((int'(sel_vc) + 1) % VC_NUM);
  end

  always_comb begin
    if (flit_cnt == '0) ftype = (len_q == '0) ? T_HT : T_HEAD;
    else if (last)      ftype = T_TAIL;
    else                ftype = T_BODY;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    pkt_ready_o     = 1'b0;
    payload_ready_o = 1'b0;
    case (state)
      IDLE: begin
        pkt_ready_o = 1'b1;
        if (pkt_valid_i) state_nxt = SELECT;
      end
      SELECT: if (sel_found) state_nxt = SEND;
      SEND: begin
        payload_ready_o = (credit[cur_vc] != '0);
        if (fire && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= '0;
      y_q            <= '0;
      len_q          <= '0;
      flit_cnt       <= '0;
      cur_vc         <= '0;
      rr_ptr         <= '0;
      flit_valid_o   <= 1'b0;
      flit_type_o    <= '0;
      flit_vc_o      <= '0;
      flit_x_dest_o  <= '0;
      flit_y_dest_o  <= '0;
      flit_payload_o <= '0;
      credit_err_o   <= 1'b0;
    end else begin
      flit_valid_o <= fire;
      if (state == IDLE && pkt_valid_i) begin
        x_q      <= pkt_x_dest_i;
        y_q      <= pkt_y_dest_i;
        len_q    <= pkt_len_i;
        flit_cnt <= '0;
      end
      if (state == SELECT && sel_found) begin
        cur_vc <= sel_vc;
        rr_ptr <= rr_nxt;
      end
      // Fields only move on a handshake so bubbles keep the last flit visible.
      if (fire) begin
        flit_type_o    <= ftype;
        flit_vc_o      <= cur_vc;
        flit_x_dest_o  <= x_q;
        flit_y_dest_o  <= y_q;
        flit_payload_o <= payload_i;
        flit_cnt       <= flit_cnt + 1'b1;
      end
      if (|ovf) credit_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ni_packetizer.sv
module tb_ni_packetizer;
  localparam int XW = 4, YW = 4, VCN = 2, BS = 8, PW = 32, ML = 16;
  localparam int VCW = 1, LW = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic pkt_valid_i = 1'b0, pkt_ready_o;
  logic [XW-1:0] pkt_x_dest_i = '0;
  logic [YW-1:0] pkt_y_dest_i = '0;
  logic [LW-1:0] pkt_len_i = '0;
  logic payload_valid_i = 1'b0, payload_ready_o;
  logic [PW-1:0] payload_i = '0;
  logic flit_valid_o;
  logic [1:0] flit_type_o;
  logic [VCW-1:0] flit_vc_o;
  logic [XW-1:0] flit_x_dest_o;
  logic [YW-1:0] flit_y_dest_o;
  logic [PW-1:0] flit_payload_o;
  logic credit_valid_i = 1'b0;
  logic [VCW-1:0] credit_vc_i = '0;
  logic credit_err_o;

  ni_packetizer #(
    .DEST_ADDR_SIZE_X(XW), .DEST_ADDR_SIZE_Y(YW), .VC_NUM(VCN),
    .BUFFER_SIZE(BS), .PAYLOAD_SIZE(PW), .MAX_PKT_LEN(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_x_dest_i(pkt_x_dest_i), .pkt_y_dest_i(pkt_y_dest_i), .pkt_len_i(pkt_len_i),
    .payload_valid_i(payload_valid_i), .payload_ready_o(payload_ready_o), .payload_i(payload_i),
    .flit_valid_o(flit_valid_o), .flit_type_o(flit_type_o), .flit_vc_o(flit_vc_o),
    .flit_x_dest_o(flit_x_dest_o), .flit_y_dest_o(flit_y_dest_o), .flit_payload_o(flit_payload_o),
    .credit_valid_i(credit_valid_i), .credit_vc_i(credit_vc_i), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;

  // Flit monitor: every observed flit with the clock edge that produced it.
  typedef struct {
    logic [1:0] t; logic [VCW-1:0] vc; logic [XW-1:0] x; logic [YW-1:0] y;
    logic [PW-1:0] p; int cyc;
  } flit_t;
  flit_t fq[$];
  always @(negedge clk) begin
    flit_t f;
    if (flit_valid_o) begin
      f.t = flit_type_o; f.vc = flit_vc_o; f.x = flit_x_dest_o; f.y = flit_y_dest_o;
      f.p = flit_payload_o; f.cyc = cyc;
      fq.push_back(f);
    end
  end

  // Payload source: presents the head of pl_q, optionally with random stalls.
  logic [PW-1:0] pl_q[$];
  int stall_pct = 0;
  bit hs_pend = 0;
  always @(negedge clk) begin
    if (hs_pend && pl_q.size() > 0) void'(pl_q.pop_front());
    if (pl_q.size() > 0 && (stall_pct == 0 || $urandom_range(99) >= stall_pct)) begin
      payload_valid_i = 1'b1;
      payload_i       = pl_q[0];
    end else payload_valid_i = 1'b0;
    hs_pend = payload_valid_i && payload_ready_o;
  end

  // Reference model: per-VC credits, round-robin pointer, sticky error.
  int mdl_cr[VCN];
  int mdl_rr;
  bit mdl_err;

  function automatic void mdl_reset();
    for (int v = 0; v < VCN; v++) mdl_cr[v] = BS;
    mdl_rr  = 0;
    mdl_err = 0;
  endfunction

  // VC a packet gets: first fully drained VC at or after the pointer.
  function automatic int pick_vc();
    for (int i = 0; i < VCN; i++)
      if (mdl_cr[(mdl_rr + i) % VCN] == BS) return (mdl_rr + i) % VCN;
    return -1;
  endfunction

  function automatic logic [1:0] exp_type(input int i, input int len);
    if (i == 0) return (len == 0) ? 2'b11 : 2'b00;
    if (i == len) return 2'b10;
    return 2'b01;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after the accepting edge; acc = that edge.
  task automatic send_req(input int x, input int y, input int len, output int acc);
    pkt_valid_i = 1'b1; pkt_x_dest_i = XW'(x); pkt_y_dest_i = YW'(y); pkt_len_i = LW'(len);
    acc = -1;
    for (int k = 0; k < 300 && acc < 0; k++) begin
      if (pkt_ready_o) acc = cyc + 1;
      @(negedge clk);
    end
    pkt_valid_i = 1'b0;
    if (acc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL req_timeout: request not accepted within 300 cycles");
    end
  endtask

  task automatic ret_credit(input int v, output int edge_no);
    credit_valid_i = 1'b1; credit_vc_i = VCW'(v);
    edge_no = cyc + 1;
    @(negedge clk);
    credit_valid_i = 1'b0;
    if (mdl_cr[v] < BS) mdl_cr[v]++;
    else mdl_err = 1;
  endtask

  task automatic drain();
    int e;
    for (int v = 0; v < VCN; v++) while (mdl_cr[v] < BS) ret_credit(v, e);
  endtask

  task automatic wait_flits(input int n, input int budget);
    int k = 0;
    while (fq.size() < n && k < budget) begin @(negedge clk); k++; end
    if (fq.size() < n) begin
      n_cmp++; n_fail++;
      $display("FAIL flit_timeout: got %0d flits, required %0d", fq.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_cmp++; if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", flit_valid_o); end
    n_cmp++; if ({flit_type_o, flit_vc_o, flit_x_dest_o, flit_y_dest_o, flit_payload_o} !== '0) begin
      n_fail++; $display("FAIL rst_fields: got %h want 0", {flit_type_o, flit_vc_o, flit_x_dest_o, flit_y_dest_o, flit_payload_o}); end
    n_cmp++; if (credit_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", credit_err_o); end
    n_cmp++; if (pkt_ready_o !== 1'b1 || payload_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready: got pkt %b pl %b want 1 0", pkt_ready_o, payload_ready_o); end
    for (int v = 0; v < VCN; v++) begin
      n_cmp++; if (dut.credit[v] !== 4'(BS)) begin n_fail++; $display("FAIL rst_credit%0d: got %0d want %0d", v, dut.credit[v], BS); end
    end
    rst = 1'b0;
    mdl_reset();
    fq.delete();
    tick();
  endtask

  task automatic test_single();
    int acc, ev;
    flit_t f;
    ev = pick_vc(); mdl_rr = (ev + 1) % VCN;
    pl_q.push_back(32'hA5);
    send_req(3, 1, 0, acc);
    wait_flits(1, 20);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      n_cmp++; if (f.t !== 2'b11) begin n_fail++; $display("FAIL single_type: got %b want 11", f.t); end
      n_cmp++; if (f.vc !== VCW'(ev)) begin n_fail++; $display("FAIL single_vc: got %0d want %0d", f.vc, ev); end
      n_cmp++; if (f.x !== 4'd3 || f.y !== 4'd1) begin n_fail++; $display("FAIL single_dest: got %0d,%0d want 3,1", f.x, f.y); end
      n_cmp++; if (f.p !== 32'hA5) begin n_fail++; $display("FAIL single_payload: got %h want a5", f.p); end
      n_cmp++; if (f.cyc !== acc + 2) begin n_fail++; $display("FAIL single_latency: got edge %0d want %0d", f.cyc, acc + 2); end
    end
    mdl_cr[ev]--;
    tick(3);
    n_cmp++; if (fq.size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra flits want 0", fq.size()); end
    n_cmp++; if (dut.credit[ev] !== 4'(mdl_cr[ev])) begin n_fail++; $display("FAIL single_credit: got %0d want %0d", dut.credit[ev], mdl_cr[ev]); end
    drain();
  endtask

  task automatic test_multi();
    int acc, ev, x, y;
    logic [PW-1:0] w[4];
    flit_t f;
    ev = pick_vc(); mdl_rr = (ev + 1) % VCN;
    x = $urandom_range(15); y = $urandom_range(15);
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; pl_q.push_back(w[i]); end
    send_req(x, y, 3, acc);
    wait_flits(4, 30);
    for (int i = 0; i < 4 && fq.size() > 0; i++) begin
      f = fq.pop_front();
      n_cmp++; if (f.t !== exp_type(i, 3) || f.vc !== VCW'(ev)) begin
        n_fail++; $display("FAIL multi_type%0d: got t%b vc%0d want t%b vc%0d", i, f.t, f.vc, exp_type(i, 3), ev); end
      n_cmp++; if (f.p !== w[i] || f.x !== XW'(x) || f.y !== YW'(y)) begin
        n_fail++; $display("FAIL multi_data%0d: got %h (%0d,%0d) want %h (%0d,%0d)", i, f.p, f.x, f.y, w[i], x, y); end
      n_cmp++; if (f.cyc !== acc + 2 + i) begin n_fail++; $display("FAIL multi_cycle%0d: got %0d want %0d", i, f.cyc, acc + 2 + i); end
    end
    mdl_cr[ev] -= 4;
    n_cmp++; if (dut.credit[ev] !== 4'(mdl_cr[ev])) begin n_fail++; $display("FAIL multi_credit: got %0d want %0d", dut.credit[ev], mdl_cr[ev]); end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc, e, v[3];
    flit_t f;
    for (int k = 0; k < 2; k++) begin
      v[k] = pick_vc(); mdl_rr = (v[k] + 1) % VCN; mdl_cr[v[k]]--;
      pl_q.push_back(32'h100 + k);
      send_req(k, k, 0, acc);
    end
    pl_q.push_back(32'h102);
    send_req(2, 2, 0, acc);
    tick(10);
    n_cmp++; if (fq.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d flits want 2", fq.size()); end
    for (int k = 0; k < 2 && fq.size() > 0; k++) begin
      f = fq.pop_front();
      n_cmp++; if (f.vc !== VCW'(v[k]) || f.p !== 32'h100 + k) begin
        n_fail++; $display("FAIL b2b_vc%0d: got vc%0d %h want vc%0d %h", k, f.vc, f.p, v[k], 32'h100 + k); end
    end
    fq.delete();
    ret_credit(0, e);
    v[2] = pick_vc(); mdl_rr = (v[2] + 1) % VCN; mdl_cr[v[2]]--;
    wait_flits(1, 20);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      n_cmp++; if (f.vc !== VCW'(v[2]) || f.cyc !== e + 2) begin
        n_fail++; $display("FAIL b2b_wait: got vc%0d edge %0d want vc%0d edge %0d", f.vc, f.cyc, v[2], e + 2); end
    end
    drain();
  endtask

  task automatic test_credit_stall();
    int acc, ev, e;
    logic [PW-1:0] w[10];
    flit_t f;
    ev = pick_vc(); mdl_rr = (ev + 1) % VCN;
    for (int i = 0; i < 10; i++) begin w[i] = $urandom; pl_q.push_back(w[i]); end
    send_req(5, 6, 9, acc);
    tick(20);
    n_cmp++; if (fq.size() != BS) begin n_fail++; $display("FAIL stall_count: got %0d flits want %0d", fq.size(), BS); end
    n_cmp++; if (payload_ready_o !== 1'b0 || flit_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_bubble: got ready %b valid %b want 0 0", payload_ready_o, flit_valid_o); end
    for (int i = 0; i < BS && fq.size() > 0; i++) begin
      f = fq.pop_front();
      n_cmp++; if (f.t !== exp_type(i, 9) || f.p !== w[i] || f.vc !== VCW'(ev)) begin
        n_fail++; $display("FAIL stall_flit%0d: got t%b %h vc%0d want t%b %h vc%0d", i, f.t, f.p, f.vc, exp_type(i, 9), w[i], ev); end
    end
    mdl_cr[ev] -= BS;
    fq.delete();
    for (int i = BS; i < 10; i++) begin
      ret_credit(ev, e);
      mdl_cr[ev]--;
      wait_flits(1, 10);
      if (fq.size() > 0) begin
        f = fq.pop_front();
        n_cmp++; if (f.t !== exp_type(i, 9) || f.p !== w[i] || f.cyc !== e + 1) begin
          n_fail++; $display("FAIL resume_flit%0d: got t%b %h edge %0d want t%b %h edge %0d", i, f.t, f.p, f.cyc, exp_type(i, 9), w[i], e + 1); end
      end
      tick(2);
    end
    drain();
  endtask

  task automatic test_random();
    int acc, ev, len, x, y, got, e, k;
    logic [PW-1:0] w[ML];
    flit_t f;
    stall_pct = 30;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(ML - 1); x = $urandom_range(15); y = $urandom_range(15);
      ev = pick_vc(); mdl_rr = (ev + 1) % VCN;
      for (int i = 0; i <= len; i++) begin w[i] = $urandom; pl_q.push_back(w[i]); end
      send_req(x, y, len, acc);
      got = 0; k = 0;
      while (got <= len && k < 600) begin
        while (fq.size() > 0) begin
          f = fq.pop_front();
          n_cmp++; if (f.t !== exp_type(got, len) || f.vc !== VCW'(ev)) begin
            n_fail++; $display("FAIL rand_type p%0d f%0d: got t%b vc%0d want t%b vc%0d", p, got, f.t, f.vc, exp_type(got, len), ev); end
          n_cmp++; if (f.p !== w[got] || f.x !== XW'(x) || f.y !== YW'(y)) begin
            n_fail++; $display("FAIL rand_data p%0d f%0d: got %h (%0d,%0d) want %h (%0d,%0d)", p, got, f.p, f.x, f.y, w[got], x, y); end
          mdl_cr[ev]--; got++;
        end
        if (mdl_cr[ev] < BS && $urandom_range(1) == 1) ret_credit(ev, e);
        else tick();
        k++;
      end
      if (got <= len) begin n_cmp++; n_fail++; $display("FAIL rand_timeout p%0d: got %0d flits want %0d", p, got, len + 1); end
      stall_pct = 0; drain(); stall_pct = 30;
    end
    stall_pct = 0;
    tick(2);
    for (int v = 0; v < VCN; v++) begin
      n_cmp++; if (dut.credit[v] !== 4'(mdl_cr[v])) begin n_fail++; $display("FAIL rand_credit%0d: got %0d want %0d", v, dut.credit[v], mdl_cr[v]); end
    end
  endtask

  task automatic test_credit_err();
    int acc, ev, ov, e;
    flit_t f;
    ev = pick_vc(); mdl_rr = (ev + 1) % VCN;
    pl_q.push_back(32'h11); pl_q.push_back(32'h22);
    send_req(1, 2, 1, acc);
    @(negedge clk);
    credit_valid_i = 1'b1; credit_vc_i = VCW'(ev);   // lands on the HEAD send edge
    @(negedge clk);
    credit_valid_i = 1'b0;
    n_cmp++; if (dut.credit[ev] !== 4'(BS) || credit_err_o !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle: got credit %0d err %b want %0d 0", dut.credit[ev], credit_err_o, BS); end
    wait_flits(2, 10);
    for (int i = 0; i < 2 && fq.size() > 0; i++) begin
      f = fq.pop_front();
      n_cmp++; if (f.t !== exp_type(i, 1)) begin n_fail++; $display("FAIL same_cycle_type%0d: got %b want %b", i, f.t, exp_type(i, 1)); end
    end
    mdl_cr[ev] = BS - 1;
    n_cmp++; if (dut.credit[ev] !== 4'(mdl_cr[ev])) begin n_fail++; $display("FAIL same_cycle_after: got %0d want %0d", dut.credit[ev], mdl_cr[ev]); end
    drain();
    ov = (ev + 1) % VCN;
    ret_credit(ov, e);
    tick(3);
    n_cmp++; if (credit_err_o !== mdl_err) begin n_fail++; $display("FAIL overflow_err: got %b want %b", credit_err_o, mdl_err); end
    n_cmp++; if (dut.credit[ov] !== 4'(BS)) begin n_fail++; $display("FAIL overflow_sat: got %0d want %0d", dut.credit[ov], BS); end
  endtask

  task automatic test_reset_mid();
    int acc;
    flit_t f;
    for (int i = 0; i < 4; i++) pl_q.push_back($urandom);
    send_req(7, 7, 3, acc);
    wait_flits(1, 20);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (flit_valid_o !== 1'b0 || pkt_ready_o !== 1'b1 || payload_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: got valid %b pkt_rdy %b pl_rdy %b want 0 1 0", flit_valid_o, pkt_ready_o, payload_ready_o); end
    n_cmp++; if (dut.credit[0] !== 4'(BS) || dut.credit[1] !== 4'(BS)) begin
      n_fail++; $display("FAIL midrst_credit: got %0d %0d want %0d", dut.credit[0], dut.credit[1], BS); end
    n_cmp++; if (credit_err_o !== 1'b0 || dut.rr_ptr !== '0) begin
      n_fail++; $display("FAIL midrst_state: got err %b ptr %0d want 0 0", credit_err_o, dut.rr_ptr); end
    rst = 1'b0;
    pl_q.delete(); fq.delete(); mdl_reset();
    tick(2);
    n_cmp++; if (fq.size() != 0) begin n_fail++; $display("FAIL midrst_tail: got %0d flits after reset want 0", fq.size()); end
    pl_q.push_back(32'hBEEF);
    send_req(2, 3, 0, acc);
    wait_flits(1, 20);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      n_cmp++; if (f.vc !== VCW'(pick_vc()) || f.t !== 2'b11 || f.p !== 32'hBEEF) begin
        n_fail++; $display("FAIL midrst_next: got vc%0d t%b %h want vc%0d t11 beef", f.vc, f.t, f.p, pick_vc()); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_credit_stall();
    test_random();
    test_credit_err();
    test_reset_mid();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
